// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single-outstanding command front-end for a small register RAM.
// Sequences the RAM pins for READ/WRITE/CLEAR and returns data plus an error flag.
module ram_access_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic          busy,
  output logic          mem_cs,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_mem_cs;
  logic          r_mem_rw;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_resp_data;
  logic          r_resp_err;

  logic w_addr_ok;
  logic w_rw_op;

  assign w_addr_ok = (req_addr <= LAST_ADDR);
  assign w_rw_op   = (req_op == OP_READ) || (req_op == OP_WRITE);

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign mem_cs     = r_mem_cs;
  assign mem_rw     = r_mem_rw;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_rw_op && w_addr_ok) begin
              r_mem_addr  <= req_addr;
              r_mem_wdata <= (req_op == OP_WRITE) ? req_wdata : '0;
              r_mem_rw    <= (req_op == OP_WRITE);
              r_mem_cs    <= 1'b1;
              r_state     <= S_ACCESS;
            end else if (req_op == OP_CLEAR) begin
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              r_mem_rw    <= 1'b1;
              r_mem_cs    <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_CLEAR;
            end else begin
              // Bad address or reserved op: answer immediately, RAM untouched.
              r_resp_err  <= 1'b1;
              r_resp_data <= '0;
              r_state     <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          r_resp_data <= r_mem_rw ? '0 : mem_rdata;
          r_resp_err  <= 1'b0;
          r_mem_cs    <= 1'b0;
          r_mem_rw    <= 1'b0;
          r_state     <= S_RESP;
        end
        S_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_mem_cs    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_mem_addr <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed stimulus with a response scoreboard for ram_access_ctrl.
// A behavioural 4x8 RAM model sits on the mem_* pins.
module tb_ram_access_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       busy;
  logic       mem_cs;
  logic       mem_rw;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t scoreQ[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] ram [0:3];

  ram_access_ctrl #(.DEPTH(4), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs && mem_rw && (mem_addr < 8'd4)) ram[mem_addr[1:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_addr < 8'd4) ? ram[mem_addr[1:0]] : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pops one expected response per completed response handshake.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (scoreQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL resp_unexpected: got data %0h err %0b expected no response", resp_data, resp_err);
      end else begin
        exp_t e;
        e = scoreQ.pop_front();
        checkOutput("resp_data", 32'(resp_data), 32'(e.d));
        checkOutput("resp_err", 32'(resp_err), 32'(e.e));
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                               input logic [7:0] expD, input logic expE, input int expLat,
                               input int expCs, input int hold);
    int lat;
    int cs;
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    scoreQ.push_back('{d: expD, e: expE});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    lat = 1;
    cs  = 0;
    while (!resp_valid && lat < 50) begin
      if (mem_cs) begin
        cs++;
        if (op == 2'b10) begin
          checkOutput("clr_addr", 32'(mem_addr), 32'(cs - 1));
          checkOutput("clr_wdata", 32'(mem_wdata), 32'h0);
          checkOutput("clr_rw", 32'(mem_rw), 32'h1);
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    if (mem_cs) cs++;
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("cs_cycles", 32'(cs), 32'(expCs));
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold_valid", 32'(resp_valid), 32'h1);
      checkOutput("hold_data", 32'(resp_data), 32'(expD));
      checkOutput("hold_req_ready", 32'(req_ready), 32'h0);
      checkOutput("hold_busy", 32'(busy), 32'h1);
      checkOutput("hold_cs", 32'(mem_cs), 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_req_ready", 32'(req_ready), 32'h1);
    checkOutput("idle_resp_valid", 32'(resp_valid), 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = 8'h00;
    req_wdata  = 8'h00;
    resp_ready = 1'b1;
    #2;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_mem_cs", 32'(mem_cs), 32'h0);
    checkOutput("rst_resp_data", 32'(resp_data), 32'h0);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic write/read");
    applyStimulus(2'b01, 8'd2, 8'hA5, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b00, 8'd2, 8'h00, 8'hA5, 1'b0, 2, 1, 0);

    $display("[TB] fill and read back");
    applyStimulus(2'b01, 8'd0, 8'h11, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b01, 8'd1, 8'h22, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b01, 8'd2, 8'h33, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b01, 8'd3, 8'h44, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b00, 8'd3, 8'h00, 8'h44, 1'b0, 2, 1, 0);
    applyStimulus(2'b00, 8'd0, 8'h00, 8'h11, 1'b0, 2, 1, 0);

    $display("[TB] error cases");
    applyStimulus(2'b00, 8'h04, 8'h00, 8'h00, 1'b1, 1, 0, 0);
    applyStimulus(2'b01, 8'hFF, 8'h77, 8'h00, 1'b1, 1, 0, 0);
    applyStimulus(2'b11, 8'h01, 8'h00, 8'h00, 1'b1, 1, 0, 0);
    applyStimulus(2'b00, 8'd1, 8'h00, 8'h22, 1'b0, 2, 1, 0);

    $display("[TB] clear");
    applyStimulus(2'b01, 8'd0, 8'hC1, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b01, 8'd2, 8'hC3, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b10, 8'h00, 8'h00, 8'h00, 1'b0, 5, 4, 0);
    for (int a = 0; a < 4; a++)
      applyStimulus(2'b00, 8'(a), 8'h00, 8'h00, 1'b0, 2, 1, 0);

    $display("[TB] response backpressure");
    applyStimulus(2'b01, 8'd1, 8'h5A, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b00, 8'd1, 8'h00, 8'h5A, 1'b0, 2, 1, 10);

    $display("[TB] reset during clear");
    applyStimulus(2'b01, 8'd0, 8'h77, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b01, 8'd2, 8'h88, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b01, 8'd3, 8'h99, 8'h00, 1'b0, 2, 1, 0);
    req_valid = 1'b1;
    req_op    = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_clr_addr", 32'(mem_addr), 32'h2);
    checkOutput("mid_clr_cs", 32'(mem_cs), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_mem_cs", 32'(mem_cs), 32'h0);
    checkOutput("arst_mem_rw", 32'(mem_rw), 32'h0);
    checkOutput("arst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("arst_req_ready", 32'(req_ready), 32'h1);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'h1);
    applyStimulus(2'b00, 8'd3, 8'h00, 8'h99, 1'b0, 2, 1, 0);
    applyStimulus(2'b00, 8'd2, 8'h00, 8'h88, 1'b0, 2, 1, 0);
    applyStimulus(2'b00, 8'd1, 8'h00, 8'h00, 1'b0, 2, 1, 0);
    applyStimulus(2'b00, 8'd0, 8'h00, 8'h00, 1'b0, 2, 1, 0);

    for (int i = 0; i < 20 && scoreQ.size() != 0; i++) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(scoreQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
